// File: rtl/simd_mem_pkg.sv
// Shared types and helpers for the banked SIMD memory.
package simd_mem_pkg;

  // Per-lane progress through one request
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } lane_state_e;

  // Word-interleaved bank select: the low bw address bits pick the bank
  function automatic int bank_of(input logic [31:0] addr, input int bw);
    logic [31:0] m;
    m = (32'd1 << bw) - 32'd1;
    return int'(addr & m);
  endfunction

endpackage

// File: rtl/simd_mem_bank.sv
// One memory bank: byte-strobed write storage and an RD_LAT-deep read
// pipeline carrying {valid, lane_mask, rdata}. The array is plain behavioural
// storage so the synthesis tool maps it onto block RAM with its output register.
module simd_mem_bank #(
  parameter int NUM_THREADS = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BANK_DEPTH  = 512,
  parameter int RD_LAT      = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [$clog2(BANK_DEPTH)-1:0]  row_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic [NUM_THREADS-1:0]         mask_i,
  output logic                           vld_o,
  output logic [NUM_THREADS-1:0]         mask_o,
  output logic [DATA_WIDTH-1:0]          rdata_o
);

  logic [DATA_WIDTH-1:0]  mem_q  [BANK_DEPTH];
  logic [RD_LAT-1:0]      vld_q;
  logic [NUM_THREADS-1:0] mask_q [RD_LAT];
  logic [DATA_WIDTH-1:0]  data_q [RD_LAT];

  // Byte-strobed write, committed on the grant edge; contents survive reset
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int s = 0; s < DATA_WIDTH / 8; s++) begin
        if (wstrb_i[s]) mem_q[row_i][8*s +: 8] <= wdata_i[8*s +: 8];
      end
    end
  end

  // Read valid shift chain; reset drops any in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= en_i && !we_i;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Read data and lane mask travel alongside the valid bit
  always_ff @(posedge clk) begin
    mask_q[0] <= mask_i;
    data_q[0] <= mem_q[row_i];
    for (int i = 1; i < RD_LAT; i++) begin
      mask_q[i] <= mask_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  assign vld_o   = vld_q[RD_LAT-1];
  assign mask_o  = mask_q[RD_LAT-1];
  assign rdata_o = data_q[RD_LAT-1];

endmodule

// File: rtl/banked_simd_mem.sv
// Banked, word-interleaved SIMD memory. Each bank grants its lowest pending
// lane per cycle; same-row reads in that bank ride along (broadcast).
// Handshake: req_* is presented and held until rsp_done pulses for one cycle;
// rsp_rdata is valid in that cycle and req_* may change in it. Lanes return to
// IDLE the following cycle, so grants for a new request start one cycle later.
module banked_simd_mem
  import simd_mem_pkg::*;
#(
  parameter int NUM_THREADS = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int BANKS       = 4,
  parameter int BANK_DEPTH  = 512,
  parameter int RD_LAT      = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_THREADS-1:0]                  req_en,
  input  logic                                    req_we,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [NUM_THREADS-1:0][31:0]            req_addr,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0]  rsp_rdata,
  output logic                                    rsp_done,
  output logic [NUM_THREADS-1:0][1:0]             lane_state_o
);

  localparam int BW = $clog2(BANKS);
  localparam int RW = $clog2(BANK_DEPTH);

  lane_state_e state_q [NUM_THREADS];
  lane_state_e state_d [NUM_THREADS];
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic done_q, done_d;

  int                     lane_bank  [NUM_THREADS];
  logic [RW-1:0]          lane_row   [NUM_THREADS];
  logic [NUM_THREADS-1:0] cand;
  logic                   win_vld    [BANKS];
  int                     win_idx    [BANKS];
  logic [NUM_THREADS-1:0] issue_mask [BANKS];

  logic                   b_vld   [BANKS];
  logic [NUM_THREADS-1:0] b_mask  [BANKS];
  logic [DATA_WIDTH-1:0]  b_rdata [BANKS];

  // Lane decode, per-bank lowest-index priority pick and read coalescing
  always_comb begin
    for (int l = 0; l < NUM_THREADS; l++) begin
      lane_bank[l] = bank_of(req_addr[l], BW);
      lane_row[l]  = req_addr[l][BW +: RW];
      cand[l]      = req_en[l] && (state_q[l] == IDLE) && !done_q;
    end
    for (int b = 0; b < BANKS; b++) begin
      win_vld[b]    = 1'b0;
      win_idx[b]    = 0;
      issue_mask[b] = '0;
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (!win_vld[b] && cand[l] && (lane_bank[l] == b)) begin
          win_vld[b] = 1'b1;
          win_idx[b] = l;
        end
      end
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (win_vld[b] && cand[l] && (lane_bank[l] == b) &&
            ((l == win_idx[b]) || (!req_we && (lane_row[l] == lane_row[win_idx[b]]))))
          issue_mask[b][l] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    simd_mem_bank #(
      .NUM_THREADS (NUM_THREADS),
      .DATA_WIDTH  (DATA_WIDTH),
      .BANK_DEPTH  (BANK_DEPTH),
      .RD_LAT      (RD_LAT)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .en_i    (win_vld[b]),
      .we_i    (req_we),
      .row_i   (lane_row[win_idx[b]]),
      .wdata_i (req_wdata[win_idx[b]]),
      .wstrb_i (req_wstrb[win_idx[b]]),
      .mask_i  (issue_mask[b]),
      .vld_o   (b_vld[b]),
      .mask_o  (b_mask[b]),
      .rdata_o (b_rdata[b])
    );
  end

  // Lane next state, read-data landing and completion detect.
  // Only ISSUED lanes sit in a read pipeline, so "every enabled lane DONE"
  // also means every pipeline is empty.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (done_q) begin
      for (int l = 0; l < NUM_THREADS; l++) state_d[l] = IDLE;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        for (int l = 0; l < NUM_THREADS; l++) begin
          if (issue_mask[b][l]) state_d[l] = req_we ? DONE : ISSUED;
          if (b_vld[b] && b_mask[b][l]) begin
            state_d[l] = DONE;
            rdata_d[l] = b_rdata[b];
          end
        end
      end
      done_d = |req_en;
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (req_en[l] && (state_d[l] != DONE)) done_d = 1'b0;
      end
    end
  end

  // Lane state, response data and done pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < NUM_THREADS; l++) state_q[l] <= IDLE;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Debug view of the lane state machines
  always_comb begin
    for (int l = 0; l < NUM_THREADS; l++) lane_state_o[l] = state_q[l];
  end

  assign rsp_rdata = rdata_q;
  assign rsp_done  = done_q;

`ifndef SYNTHESIS
  logic busy;
  // Any lane in flight means the request must not change
  always_comb begin
    busy = 1'b0;
    for (int l = 0; l < NUM_THREADS; l++) if (state_q[l] != IDLE) busy = 1'b1;
  end

  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (busy && !done_q) |=> (done_q || ($stable(req_en) && $stable(req_we))));
`endif

endmodule
